mem_stream_reader: RTL
======================

# mem_stream_reader

Sequential reader for the accelerator's registered-read dual-port RAM (one-cycle read latency, data valid the cycle after the address is presented). Given a base address and word count, it issues consecutive read addresses and delivers the words as a valid/ready stream with full backpressure. It feeds weight and activation words from RAM to downstream compute units.

## Interface
- DEPTH, 8, address width; the RAM holds 2**DEPTH words
- WIDTH, 16, data word width
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a burst; sampled only in IDLE
- base_addr  in  DEPTH  first word address; sampled with start
- length  in  DEPTH+1  word count, 0..2**DEPTH; sampled with start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when a burst completes
- mem_read_addr  out  DEPTH  read address to the RAM
- mem_data  in  WIDTH  RAM read data; reflects the address presented one cycle earlier
- out_data  out  WIDTH  stream payload
- out_valid  out  1  payload valid
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready
- out_last  out  1  high with the final word of a burst

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 with length>0 latches base_addr into the address counter and length into the remaining counter, then goes to RUN. start=1 with length=0 stays in IDLE and pulses done in the next cycle with no output. start is ignored outside IDLE.
- RUN: issues one read per cycle when remaining>0 and credit is available; each issue drives mem_read_addr=addr, then increments addr and decrements remaining. When the last read is issued, goes to DRAIN.
- Credit rule: issue only if fifo_count + inflight - pop < 2. inflight is the read issued last cycle. pop is the current cycle's output transfer.
- An issued read is captured from mem_data into a 2-entry output FIFO on the next edge, unconditionally. The FIFO therefore never overflows.
- DRAIN: waits until inflight=0 and the FIFO is empty after the final transfer, then goes to IDLE and pulses done.
- Address arithmetic is modulo 2**DEPTH. A burst crossing the top address wraps to 0.
- out_last is tagged at issue time on the read that takes remaining from 1 to 0, and travels with the word through the FIFO.
- mem_read_addr holds its last value when not issuing.
- Order is preserved. Each burst delivers exactly `length` words.

## Timing
- Reset values: state=IDLE, busy=0, done=0, out_valid=0, out_last=0, out_data=0, mem_read_addr=0, FIFO empty, inflight=0. Asserting reset mid-burst aborts the burst, discards buffered words, and produces no done.
- start accepted at edge 0 → cycle 1: busy=1 and mem_read_addr=base_addr → cycle 2: mem_data valid → cycle 3: first out_valid.
- With out_ready held high, throughput is 1 word per cycle. For length=N, the last transfer occurs in cycle N+2 and done pulses in cycle N+3 with busy=0.
- When out_ready is low, at most 2 words are buffered and issuing stalls. out_data, out_valid and out_last are stable while out_valid && !out_ready.
- done and start in the same cycle: the new start is accepted, because the state is already IDLE.

## Structure
- The shared package `nn_mem_pkg` holds the state enum `reader_state_t` and the `FIFO_DEPTH=2` constant.
- Sub-module `stream_fifo2`: a 2-entry synchronous FIFO with a WIDTH+1-bit payload (data + last) that exposes count, valid/ready output, and a push input.
- The top level holds the FSM, the address and remaining counters, the inflight flag and the credit logic.

## Test plan
- Basic burst: RAM[i]=i+100, base=4, length=5, out_ready=1 → out_data 104..108 in cycles 3..7, out_last only on 108, done in cycle 8.
- Wrap-around: DEPTH=8, base=254, length=4 → words from addresses 254, 255, 0, 1 in that order.
- Backpressure: length=8, out_ready toggled 1,0,0,1,… → all 8 words delivered in order, none duplicated or lost; at most 2 issues run ahead of the consumer; output held stable while stalled.
- Zero length: start with length=0 → done pulses in cycle 1, out_valid never asserts, busy stays 0.
- Full burst: base=0, length=256 → 256 words, out_last on RAM[255], done one cycle later.
- Reset mid-burst: rst_n low in cycle 4 of a length=10 burst → all outputs at reset values immediately, and no done. A new start for base=0, length=2 then works normally.

Source files
------------

// File: rtl/nn_mem_pkg.sv
// nn_mem_pkg: shared types and constants for the accelerator memory readers.
//   reader_state_t : FSM encoding for mem_stream_reader
//   FIFO_DEPTH     : entries in the reader's output FIFO
//   COUNT_W        : width of an occupancy count 0..FIFO_DEPTH
package nn_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } reader_state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int COUNT_W    = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2: 2-entry synchronous FIFO carrying {last, data}.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : write push_data this cycle (caller guarantees space)
//   push_data    : {last, data} payload, WIDTH+1 bits
//   count        : current occupancy 0..FIFO_DEPTH
//   out_valid    : head entry present
//   out_ready    : consumer takes the head entry
//   out_payload  : head entry {last, data}
module stream_fifo2
  import nn_mem_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [WIDTH:0]     push_data,
  output logic [COUNT_W-1:0] count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     out_payload
);

  logic [WIDTH:0]     entry_q [FIFO_DEPTH];
  logic [WIDTH:0]     entry_d [FIFO_DEPTH];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q,  count_d;
  logic               pop;

  assign out_valid   = (count_q != '0);
  assign pop         = out_valid && out_ready;
  assign count       = count_q;
  assign out_payload = entry_q[rd_ptr_q];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      entry_d[wr_ptr_q] = push_data;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage is reset too: it is only two words, and it makes out_data read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) entry_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments for all flops, so every register samples pre-edge values.
      for (int i = 0; i < FIFO_DEPTH; i++) entry_q[i] <= entry_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: reads `length` consecutive words from a registered-read RAM
// starting at base_addr and delivers them as a valid/ready stream.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : burst request, sampled in IDLE with base_addr/length
//   base_addr       : first word address (wraps modulo 2**DEPTH)
//   length          : word count 0..2**DEPTH
//   busy            : FSM not in IDLE
//   done            : one-cycle pulse after a burst completes
//   mem_read_addr   : RAM read address (data returns one cycle later)
//   mem_data        : RAM read data
//   out_data/valid/ready/last : output stream, last tags the final word
module mem_stream_reader
  import nn_mem_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DEPTH-1:0] base_addr,
  input  logic [DEPTH:0]   length,
  output logic             busy,
  output logic             done,
  output logic [DEPTH-1:0] mem_read_addr,
  input  logic [WIDTH-1:0] mem_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  reader_state_t      state_q, state_d;
  logic [DEPTH-1:0]   addr_q, addr_d;
  logic [DEPTH:0]     remaining_q, remaining_d;
  logic [DEPTH-1:0]   mem_read_addr_q, mem_read_addr_d;
  logic               inflight_q, inflight_d;
  logic               inflight_last_q, inflight_last_d;
  logic               done_q, done_d;

  logic [COUNT_W-1:0] fifo_count;
  logic [WIDTH:0]     fifo_payload;
  logic               pop;
  logic [2:0]         occupancy;
  logic               credit_ok;
  logic               issue;
  logic               last_issue;

  // A read issued last cycle lands in the FIFO at this edge, so it already
  // holds a slot; a word leaving this cycle frees one.
  assign pop        = out_valid && out_ready;
  assign occupancy  = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign credit_ok  = occupancy < 3'(FIFO_DEPTH);
  assign issue      = (state_q == ST_RUN) && (remaining_q != '0) && credit_ok;
  assign last_issue = issue && (remaining_q == (DEPTH+1)'(1));

  stream_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (inflight_q),
    .push_data   ({inflight_last_q, mem_data}),
    .count       (fifo_count),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (fifo_payload)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      mem_read_addr_q <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      mem_read_addr_q <= mem_read_addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    done_d          = 1'b0;
    inflight_d      = issue;
    inflight_last_d = last_issue;
    mem_read_addr_d = issue ? addr_q : mem_read_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_d      = base_addr;
            remaining_d = length;
            state_d     = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (last_issue) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave once nothing is in flight and the final word transfers now.
        if (!inflight_q &&
            ((fifo_count == '0) || ((fifo_count == COUNT_W'(1)) && pop))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    busy          = (state_q != ST_IDLE);
    done          = done_q;
    mem_read_addr = mem_read_addr_d;
    out_data      = fifo_payload[WIDTH-1:0];
    out_last      = fifo_payload[WIDTH];
  end

endmodule
